fadd_ctrl: RTL and testbench

Sequencing wrapper that sits directly upstream of the multi-cycle single-precision `adder` in the FPU. It accepts FADD.S/FSUB.S requests from the issue stage over a valid/ready handshake and negates operand B for subtraction. It holds the adder's operands stable, releases and re-asserts the adder's reset around each operation, and captures the one-cycle `output_z_stb` result. It returns a RISC-V-canonicalised result with a destination tag and exception flags over a second valid/ready handshake.

---
 rtl/fadd_ctrl_if.sv | 24 ++
 rtl/fadd_ctrl.sv | 154 +++++++++++++++
 tb/tb_fadd_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fadd_ctrl_if.sv
// rtl/fadd_ctrl_if.sv - request/response handshake bundle between issue stage and fadd_ctrl
interface fadd_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [4:0]  req_rd;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_z;
   logic [4:0]  rsp_rd;
   logic [4:0]  rsp_flags;

   modport master (
      output req_valid, req_op, req_a, req_b, req_rd, rsp_ready,
      input  req_ready, rsp_valid, rsp_z, rsp_rd, rsp_flags
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_rd, rsp_ready,
      output req_ready, rsp_valid, rsp_z, rsp_rd, rsp_flags
   );
endinterface

// File: rtl/fadd_ctrl.sv
// rtl/fadd_ctrl.sv - sequencer around the multi-cycle FP adder
// Holds operands, pulses the adder reset, captures the strobe and canonicalises the result.
module fadd_ctrl #(
   parameter int TIMEOUT = 511
) (
   input  logic        clk,
   input  logic        rst_n,
   fadd_ctrl_if.slave  io,
   input  logic        flush,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_rst,
   input  logic [31:0] add_z,
   input  logic        add_stb,
   output logic        busy
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [31:0]   QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [31:0]   add_a_q, add_a_d;
   logic [31:0]   add_b_q, add_b_d;
   logic          add_rst_q, add_rst_d;
   logic [4:0]    tag_q, tag_d;
   logic          nv_q, nv_d;
   logic          inf_in_q, inf_in_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   rsp_z_q, rsp_z_d;
   logic [4:0]    rsp_rd_q, rsp_rd_d;
   logic [4:0]    rsp_flags_q, rsp_flags_d;

   logic [31:0] b_neg;
   logic        accept;
   logic        a_exp_max, b_exp_max, z_exp_max;
   logic        a_snan, b_snan, a_inf, b_inf, z_nan, z_inf;

   assign b_neg     = {io.req_b[31] ^ io.req_op, io.req_b[30:0]};
   assign a_exp_max = (io.req_a[30:23] == 8'hFF);
   assign b_exp_max = (b_neg[30:23] == 8'hFF);
   assign z_exp_max = (add_z[30:23] == 8'hFF);
   assign a_snan    = a_exp_max && (io.req_a[22:0] != 23'd0) && !io.req_a[22];
   assign b_snan    = b_exp_max && (b_neg[22:0] != 23'd0) && !b_neg[22];
   assign a_inf     = a_exp_max && (io.req_a[22:0] == 23'd0);
   assign b_inf     = b_exp_max && (b_neg[22:0] == 23'd0);
   assign z_nan     = z_exp_max && (add_z[22:0] != 23'd0);
   assign z_inf     = z_exp_max && (add_z[22:0] == 23'd0);

   assign io.req_ready = (state_q == IDLE) && !flush;
   assign accept       = io.req_valid && io.req_ready;

   always_comb begin
      state_d     = state_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_rst_d   = add_rst_q;
      tag_d       = tag_q;
      nv_d        = nv_q;
      inf_in_d    = inf_in_q;
      cnt_d       = cnt_q;
      rsp_z_d     = rsp_z_q;
      rsp_rd_d    = rsp_rd_q;
      rsp_flags_d = rsp_flags_q;

      if (flush) begin
         state_d   = IDLE;
         add_rst_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  add_a_d   = io.req_a;
                  add_b_d   = b_neg;
                  tag_d     = io.req_rd;
                  cnt_d     = '0;
                  nv_d      = a_snan || b_snan ||
                              (a_inf && b_inf && (io.req_a[31] != b_neg[31]));
                  inf_in_d  = a_exp_max || b_exp_max;
                  add_rst_d = 1'b0;
                  state_d   = RUN;
               end
            end
            RUN: begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               // A strobe landing on the timeout edge still delivers the real result.
               if (add_stb) begin
                  rsp_z_d     = z_nan ? QNAN : add_z;
                  rsp_flags_d = {nv_q, 1'b0, z_inf && !inf_in_q, 2'b00};
                  rsp_rd_d    = tag_q;
                  add_rst_d   = 1'b1;
                  state_d     = DONE;
               end else if (cnt_q == TMO) begin
                  rsp_z_d     = QNAN;
                  rsp_flags_d = 5'b10000;
                  rsp_rd_d    = tag_q;
                  add_rst_d   = 1'b1;
                  state_d     = DONE;
               end
            end
            DONE: begin
               if (io.rsp_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d   = IDLE;
               add_rst_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_rst_q   <= 1'b1;
         tag_q       <= '0;
         nv_q        <= 1'b0;
         inf_in_q    <= 1'b0;
         cnt_q       <= '0;
         rsp_z_q     <= '0;
         rsp_rd_q    <= '0;
         rsp_flags_q <= '0;
      end else begin
         state_q     <= state_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_rst_q   <= add_rst_d;
         tag_q       <= tag_d;
         nv_q        <= nv_d;
         inf_in_q    <= inf_in_d;
         cnt_q       <= cnt_d;
         rsp_z_q     <= rsp_z_d;
         rsp_rd_q    <= rsp_rd_d;
         rsp_flags_q <= rsp_flags_d;
      end
   end

   assign add_a        = add_a_q;
   assign add_b        = add_b_q;
   assign add_rst      = add_rst_q;
   assign busy         = (state_q != IDLE);
   assign io.rsp_valid = (state_q == DONE);
   assign io.rsp_z     = rsp_z_q;
   assign io.rsp_rd    = rsp_rd_q;
   assign io.rsp_flags = rsp_flags_q;
endmodule

// File: tb/tb_fadd_ctrl.sv
// tb/tb_fadd_ctrl.sv - directed bench for fadd_ctrl; the bench plays the role of the adder
module tb_fadd_ctrl;
   localparam int TMO = 20;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] add_a, add_b;
   logic        add_rst;
   logic [31:0] add_z = '0;
   logic        add_stb = 1'b0;
   logic        busy;

   fadd_ctrl_if io();

   fadd_ctrl #(.TIMEOUT(TMO)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .io      (io),
      .flush   (flush),
      .add_a   (add_a),
      .add_b   (add_b),
      .add_rst (add_rst),
      .add_z   (add_z),
      .add_stb (add_stb),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] z;
      int          lat;
      logic [31:0] exp_b;
      logic [31:0] exp_z;
      logic [4:0]  exp_flags;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      io.req_valid = 1'b1;
      io.req_op    = op;
      io.req_a     = a;
      io.req_b     = b;
      io.req_rd    = rd;
      tick();
      io.req_valid = 1'b0;
   endtask

   task automatic run_op(input vec_t v, input string nm);
      logic stable;
      issue(v.op, v.a, v.b, v.rd);
      chk({nm, " add_rst_low"}, 32'(add_rst), 32'd0);
      chk({nm, " add_a"}, add_a, v.a);
      chk({nm, " add_b"}, add_b, v.exp_b);
      chk({nm, " req_ready_run"}, 32'(io.req_ready), 32'd0);
      stable = 1'b1;
      repeat (v.lat) begin
         tick();
         if (add_a !== v.a || add_b !== v.exp_b || io.rsp_valid !== 1'b0 || add_rst !== 1'b0)
            stable = 1'b0;
      end
      chk({nm, " run_stable"}, 32'(stable), 32'd1);
      add_z   = v.z;
      add_stb = 1'b1;
      tick();
      add_stb = 1'b0;
      add_z   = '0;
      chk({nm, " rsp_valid"}, 32'(io.rsp_valid), 32'd1);
      chk({nm, " rsp_z"}, io.rsp_z, v.exp_z);
      chk({nm, " rsp_rd"}, 32'(io.rsp_rd), 32'(v.rd));
      chk({nm, " rsp_flags"}, 32'(io.rsp_flags), 32'(v.exp_flags));
      chk({nm, " add_rst_high"}, 32'(add_rst), 32'd1);
      if (io.rsp_ready) begin
         tick();
         chk({nm, " idle"}, {30'd0, io.rsp_valid, busy}, 32'd0);
      end
   endtask

   initial begin
      logic [31:0] hz;
      logic [4:0]  hf;
      logic        ok;
      int          n;

      io.req_valid = 1'b0;
      io.req_op    = 1'b0;
      io.req_a     = '0;
      io.req_b     = '0;
      io.req_rd    = '0;
      io.rsp_ready = 1'b1;

      vecs[0] = '{op:1'b0, a:32'h3F800000, b:32'h40000000, rd:5'd5,  z:32'h40400000, lat:9,
                  exp_b:32'h40000000, exp_z:32'h40400000, exp_flags:5'b00000};
      vecs[1] = '{op:1'b1, a:32'h40400000, b:32'h40400000, rd:5'd1,  z:32'h00000000, lat:10,
                  exp_b:32'hC0400000, exp_z:32'h00000000, exp_flags:5'b00000};
      vecs[2] = '{op:1'b1, a:32'h7F800000, b:32'h7F800000, rd:5'd2,  z:32'hFFC00000, lat:9,
                  exp_b:32'hFF800000, exp_z:32'h7FC00000, exp_flags:5'b10000};
      vecs[3] = '{op:1'b0, a:32'h7F800001, b:32'h3F800000, rd:5'd3,  z:32'h7FC00001, lat:9,
                  exp_b:32'h3F800000, exp_z:32'h7FC00000, exp_flags:5'b10000};
      vecs[4] = '{op:1'b0, a:32'h7F7FFFFF, b:32'h7F7FFFFF, rd:5'd4,  z:32'h7F800000, lat:11,
                  exp_b:32'h7F7FFFFF, exp_z:32'h7F800000, exp_flags:5'b00100};
      vecs[5] = '{op:1'b0, a:32'h7F800000, b:32'h3F800000, rd:5'd6,  z:32'h7F800000, lat:12,
                  exp_b:32'h3F800000, exp_z:32'h7F800000, exp_flags:5'b00000};
      vecs[6] = '{op:1'b0, a:32'h7FC00000, b:32'h3F800000, rd:5'd7,  z:32'h7FC00000, lat:9,
                  exp_b:32'h3F800000, exp_z:32'h7FC00000, exp_flags:5'b00000};
      vecs[7] = '{op:1'b1, a:32'hFF800000, b:32'h7F800000, rd:5'd8,  z:32'hFF800000, lat:13,
                  exp_b:32'hFF800000, exp_z:32'hFF800000, exp_flags:5'b00000};
      vecs[8] = '{op:1'b1, a:32'hC0000000, b:32'hBF800000, rd:5'd31, z:32'hBF800000, lat:15,
                  exp_b:32'h3F800000, exp_z:32'hBF800000, exp_flags:5'b00000};

      repeat (3) @(posedge clk);
      #1;
      chk("reset add_rst", 32'(add_rst), 32'd1);
      chk("reset add_a", add_a, 32'd0);
      chk("reset add_b", add_b, 32'd0);
      chk("reset rsp", {io.rsp_z[26:0], io.rsp_valid, busy, 3'd0} | 32'(io.rsp_rd) | 32'(io.rsp_flags), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("reset req_ready", 32'(io.req_ready), 32'd1);

      for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // backpressure, then a back-to-back request
      io.rsp_ready = 1'b0;
      run_op(vecs[0], "bp");
      hz = io.rsp_z;
      hf = io.rsp_flags;
      ok = 1'b1;
      repeat (10) begin
         tick();
         if (io.rsp_valid !== 1'b1 || io.rsp_z !== hz || io.rsp_flags !== hf ||
             io.rsp_rd !== 5'd5 || io.req_ready !== 1'b0) ok = 1'b0;
      end
      chk("bp hold", 32'(ok), 32'd1);
      io.rsp_ready = 1'b1;
      tick();
      chk("bp release", {30'd0, io.rsp_valid, io.req_ready}, 32'd1);
      run_op(vecs[1], "bp2");

      // flush drops a pending result in DONE
      io.rsp_ready = 1'b0;
      run_op(vecs[4], "fdone");
      flush = 1'b1;
      tick();
      flush = 1'b0;
      io.rsp_ready = 1'b1;
      chk("fdone dropped", {30'd0, io.rsp_valid, busy}, 32'd0);

      // flush four cycles into RUN; a late strobe must be ignored
      issue(1'b0, 32'h3F800000, 32'h40000000, 5'd9);
      repeat (4) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("frun add_rst", 32'(add_rst), 32'd1);
      chk("frun idle", {30'd0, io.rsp_valid, busy}, 32'd0);
      add_z = 32'h40400000;
      add_stb = 1'b1;
      tick();
      add_stb = 1'b0;
      chk("frun stale_stb", {30'd0, io.rsp_valid, busy}, 32'd0);
      run_op('{op:1'b0, a:32'h3F800000, b:32'h3F800000, rd:5'd3, z:32'h40000000, lat:9,
               exp_b:32'h3F800000, exp_z:32'h40000000, exp_flags:5'b00000}, "after_flush");

      // strobe and flush in the same cycle
      issue(1'b0, 32'h3F800000, 32'h3F800000, 5'd10);
      repeat (3) tick();
      add_z = 32'h40000000;
      add_stb = 1'b1;
      flush = 1'b1;
      tick();
      add_stb = 1'b0;
      flush = 1'b0;
      chk("stb_flush", {29'd0, io.rsp_valid, busy, add_rst}, 32'd1);

      // timeout with no strobe
      issue(1'b0, 32'h3F800000, 32'h3F800000, 5'd7);
      n = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (io.rsp_valid === 1'b1) begin
            n = k;
            break;
         end
      end
      chk("timeout latency", 32'(n), 32'(TMO + 1));
      chk("timeout rsp_z", io.rsp_z, 32'h7FC00000);
      chk("timeout flags", 32'(io.rsp_flags), 32'h10);
      chk("timeout rd", 32'(io.rsp_rd), 32'd7);
      tick();

      // strobe on the timeout edge wins
      issue(1'b0, 32'h3F800000, 32'h40000000, 5'd12);
      repeat (TMO) tick();
      add_z = 32'h40400000;
      add_stb = 1'b1;
      tick();
      add_stb = 1'b0;
      chk("stb_tmo rsp_z", io.rsp_z, 32'h40400000);
      chk("stb_tmo flags", 32'(io.rsp_flags), 32'd0);
      tick();

      // asynchronous reset mid-RUN
      issue(1'b0, 32'h3F800000, 32'h40000000, 5'd13);
      repeat (2) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async add_rst", 32'(add_rst), 32'd1);
      chk("async add_a", add_a, 32'd0);
      chk("async busy", 32'(busy), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run_op(vecs[0], "post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
